// File: rtl/cpu_iack_sequencer_if.sv
// Bundle of interrupt request/acknowledge signals between the CPU core side and
// the acknowledge sequencer.
interface cpu_iack_sequencer_if;
   logic [2:0]  ipl_in;
   logic        int7;
   logic [2:0]  mask;
   logic        iack_req;
   logic        bus_ready;
   logic [15:0] data_in;
   logic [2:0]  irq_level;
   logic        irq_pending;
   logic [23:1] cpu_address;
   logic        _cpu_as;
   logic        cpu_rd;
   logic        iack_done;
   logic [7:0]  vector;

   modport master (
      output ipl_in, int7, mask, iack_req, bus_ready, data_in,
      input  irq_level, irq_pending, cpu_address, _cpu_as, cpu_rd, iack_done, vector
   );

   modport slave (
      input  ipl_in, int7, mask, iack_req, bus_ready, data_in,
      output irq_level, irq_pending, cpu_address, _cpu_as, cpu_rd, iack_done, vector
   );
endinterface

// File: rtl/cpu_iack_sequencer.sv
// Interrupt level filter, pending/NMI qualification and the bus interrupt-acknowledge
// cycle that fetches (or autovectors) the exception vector.
module cpu_iack_sequencer (
   input  logic                 clk,
   input  logic                 reset,
   cpu_iack_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  raw_q, raw_d;
   logic [2:0]  level_q, level_d;
   logic        pending_q, pending_d;
   logic        armed_q, armed_d;
   logic [2:0]  lat_q, lat_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [23:1] addr_q, addr_d;
   logic        as_n_q, as_n_d;
   logic        rd_q, rd_d;
   logic        done_q, done_d;
   logic [7:0]  vector_q, vector_d;
   logic [2:0]  raw_level;
   logic        finish;
   logic        unused_data_hi;

   assign raw_level      = bus.int7 ? 3'd7 : bus.ipl_in;
   assign unused_data_hi = ^bus.data_in[15:8];

   always_comb begin
      state_d   = state_q;
      raw_d     = raw_level;
      level_d   = level_q;
      armed_d   = armed_q;
      lat_d     = lat_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      as_n_d    = as_n_q;
      rd_d      = rd_q;
      done_d    = 1'b0;
      vector_d  = vector_q;
      finish    = 1'b0;

      // Level is accepted only once two consecutive samples agree.
      if (raw_level == raw_q) begin
         level_d = raw_level;
      end

      case (state_q)
         IDLE: begin
            if (bus.iack_req) begin
               state_d = ADDR;
               lat_d   = level_q;
               addr_d  = {20'hFFFFF, level_q};
               as_n_d  = 1'b0;
               rd_d    = 1'b1;
            end
         end
         ADDR: begin
            state_d = WAIT;
            cnt_d   = 6'd0;
         end
         WAIT: begin
            if (bus.bus_ready) begin
               vector_d = bus.data_in[7:0];
               finish   = 1'b1;
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (cnt_d == 6'd63) begin
                  vector_d = 8'd24 + {5'd0, lat_q};
                  finish   = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = 6'd0;
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         state_d = DONE;
         done_d  = 1'b1;
         as_n_d  = 1'b1;
         rd_d    = 1'b0;
         addr_d  = '0;
      end

      // A completed level-7 acknowledge disarms NMI until the level drops below 7.
      if (finish && (lat_q == 3'd7)) begin
         armed_d = 1'b0;
      end else if (level_d != 3'd7) begin
         armed_d = 1'b1;
      end

      pending_d = (level_d == 3'd7) ? armed_d : (level_d > bus.mask);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         raw_q     <= 3'd0;
         level_q   <= 3'd0;
         pending_q <= 1'b0;
         armed_q   <= 1'b1;
         lat_q     <= 3'd0;
         cnt_q     <= 6'd0;
         addr_q    <= '0;
         as_n_q    <= 1'b1;
         rd_q      <= 1'b0;
         done_q    <= 1'b0;
         vector_q  <= 8'd0;
      end else begin
         state_q   <= state_d;
         raw_q     <= raw_d;
         level_q   <= level_d;
         pending_q <= pending_d;
         armed_q   <= armed_d;
         lat_q     <= lat_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         as_n_q    <= as_n_d;
         rd_q      <= rd_d;
         done_q    <= done_d;
         vector_q  <= vector_d;
      end
   end

   assign bus.irq_level   = level_q;
   assign bus.irq_pending = pending_q;
   assign bus.cpu_address = addr_q;
   assign bus._cpu_as     = as_n_q;
   assign bus.cpu_rd      = rd_q;
   assign bus.iack_done   = done_q;
   assign bus.vector      = vector_q;
endmodule
